// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder: WIDTH-bit operands summed CHUNK bits per clock, carry held between chunks.
// Optional `ADDER_SUB_EN adds a Sub input selecting In1 - In2.
module seq_chunk_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  input  logic             Cin,
`ifdef ADDER_SUB_EN
  input  logic             Sub,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned NCH = WIDTH / CHUNK;
  localparam int unsigned CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned CP1 = CHUNK + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;

  logic             sub_c;
  logic [CHUNK:0]   chunk_full_c;
  logic             top_cin_c;

`ifdef ADDER_SUB_EN
  assign sub_c = Sub;
`else
  assign sub_c = 1'b0;
`endif

  // Operand registers are shifted right each chunk, so the live slice is always the low CHUNK bits
  assign chunk_full_c = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + CP1'(carry_q);
  assign top_cin_c    = chunk_full_c[CHUNK-1] ^ a_q[CHUNK-1] ^ b_q[CHUNK-1];

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d        = In1;
          b_d        = sub_c ? ~In2 : In2;
          carry_d    = sub_c ? 1'b1 : Cin;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        for (int i = 0; i < int'(NCH); i++) begin
          if (cnt_q == CW'(i)) sum_d[i*CHUNK +: CHUNK] = chunk_full_c[CHUNK-1:0];
        end
        carry_d = chunk_full_c[CHUNK];
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(NCH - 1)) begin
          cout_d      = chunk_full_c[CHUNK];
          ovf_d       = top_cin_c ^ chunk_full_c[CHUNK];
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign Sum       = sum_q;
  assign Cout      = cout_q;
  assign Ovf       = ovf_q;
  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;

endmodule
